// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter and access sequencer for a single-port
// on-chip RAM with a registered address and an unregistered q output.
// Grants at most one access per cycle and returns read data two cycles
// after acceptance, with a valid strobe only to the master that issued the read.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W = DATA_W / 8;

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic              rd_go;

    // last_grant = 1 means m1 was served most recently, so m0 wins next contention
    logic              last_grant_q, last_grant_d;
    logic              s1_vld_q, s1_vld_d;
    logic              s1_id_q, s1_id_d;
    logic              s2_vld_q, s2_vld_d;
    logic              s2_id_q, s2_id_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Round-robin grant; reset suppresses every grant so nothing reaches the RAM
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    // RAM drive muxed from the granted master; write wins over read when both are set
    always_comb begin
        mem_address    = m0_address;
        mem_writedata  = m0_writedata;
        mem_byteenable = m0_byteenable;
        mem_chipselect = grant0 | grant1;
        mem_write      = 1'b0;
        rd_go          = 1'b0;
        if (grant1) begin
            mem_address    = m1_address;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
            mem_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
            rd_go          = m1_read & ~m1_write;
        end else if (grant0) begin
            mem_write      = m0_write;
            mem_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
            rd_go          = m0_read & ~m0_write;
        end
    end

    assign mem_clken = 1'b1;

    // Next-state for grant history and the two-stage read tracking pipeline
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant1) begin
            last_grant_d = 1'b1;
        end else if (grant0) begin
            last_grant_d = 1'b0;
        end
        s1_vld_d = rd_go;
        s1_id_d  = grant1;
        s2_vld_d = s1_vld_q;
        s2_id_d  = s1_id_q;
        // RAM q is valid the cycle after the accept, i.e. while stage 1 holds the read
        rdata_d  = s1_vld_q ? mem_readdata : rdata_q;
    end

    // State registers; reset discards any reads still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            s1_vld_q     <= 1'b0;
            s1_id_q      <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_id_q      <= 1'b0;
            rdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_vld_q     <= s1_vld_d;
            s1_id_q      <= s1_id_d;
            s2_vld_q     <= s2_vld_d;
            s2_id_q      <= s2_id_d;
            rdata_q      <= rdata_d;
        end
    end

    assign m0_readdata      = rdata_q;
    assign m1_readdata      = rdata_q;
    assign m0_readdatavalid = s2_vld_q & ~s2_id_q;
    assign m1_readdatavalid = s2_vld_q & s2_id_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 2048x32 RAM
// (registered address, unregistered q, byte enables) on the memory side.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [10:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(11), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    // RAM model: address and write captured on the clock edge, q read from the held address
    logic [31:0] ram [0:2047];
    logic [10:0] ram_addr_q = '0;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
    endtask

    // Single uncontended write from master m
    task automatic wr(input int m, input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        if (m == 0) begin
            m0_write = 1'b1; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_write = 1'b1; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
        @(negedge clk);
        chk("wr_wait", 32'(m == 0 ? m0_waitrequest : m1_waitrequest), 32'd0);
        tick();
        idle();
    endtask

    // Single uncontended read from master m; response expected two cycles after accept
    task automatic rd(input int m, input logic [10:0] a, input logic [31:0] exp);
        if (m == 0) begin
            m0_read = 1'b1; m0_address = a; m0_byteenable = 4'h0;
        end else begin
            m1_read = 1'b1; m1_address = a; m1_byteenable = 4'h0;
        end
        @(negedge clk);
        chk("rd_wait", 32'(m == 0 ? m0_waitrequest : m1_waitrequest), 32'd0);
        chk("rd_be_ones", 32'(mem_byteenable), 32'hF);
        tick();
        idle();
        @(negedge clk);
        chk("rd_early_vld", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_vld_own", 32'(m == 0 ? m0_readdatavalid : m1_readdatavalid), 32'd1);
        chk("rd_vld_other", 32'(m == 0 ? m1_readdatavalid : m0_readdatavalid), 32'd0);
        chk("rd_data", m == 0 ? m0_readdata : m1_readdata, exp);
        tick();
        @(negedge clk);
        chk("rd_vld_one_cycle", 32'(m0_readdatavalid | m1_readdatavalid), 32'd0);
        tick();
    endtask

    initial begin
        int idx0, idx1;
        logic exp0, exp1;
        logic [31:0] expd;

        // Reset with a pending request: waitrequest mirrors req, nothing reaches the RAM
        idle();
        reset = 1'b1;
        m0_read = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wait_eq_req", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_vld", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        chk("rst_rdata", m0_readdata, 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd1);
        tick();
        reset = 1'b0;
        idle();
        tick();

        // Basic write then read through m0
        m0_write = 1'b1; m0_address = 11'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        @(negedge clk);
        chk("w1_wait", 32'(m0_waitrequest), 32'd0);
        chk("w1_cs", 32'(mem_chipselect), 32'd1);
        chk("w1_mem_write", 32'(mem_write), 32'd1);
        chk("w1_mem_addr", 32'(mem_address), 32'h005);
        chk("w1_mem_wdata", mem_writedata, 32'hDEADBEEF);
        tick();
        idle();
        rd(0, 11'h005, 32'hDEADBEEF);

        // Byte lanes
        wr(0, 11'h010, 32'h11223344, 4'hF);
        wr(0, 11'h010, 32'hAABBCCDD, 4'b0101);
        rd(0, 11'h010, 32'h11BB33DD);

        // Preload for contention and reset tests; last preload by m1 so m0 wins next contention
        for (int i = 0; i < 4; i++) wr(0, 11'(32'h100 + i), 32'hA0000000 + i, 4'hF);
        wr(0, 11'h030, 32'h12345678, 4'hF);
        for (int i = 0; i < 4; i++) wr(1, 11'(32'h200 + i), 32'hB0000000 + i, 4'hF);

        // Contention: 4 reads each, masters hold while stalled
        idx0 = 0;
        idx1 = 0;
        for (int k = 0; k < 11; k++) begin
            m0_read = (idx0 < 4); m0_address = 11'(32'h100 + idx0);
            m1_read = (idx1 < 4); m1_address = 11'(32'h200 + idx1);
            @(negedge clk);
            if (k < 8) begin
                exp0 = (k % 2 == 1) && (k < 7);
                exp1 = (k % 2 == 0);
                chk($sformatf("ct_wait0_%0d", k), 32'(m0_waitrequest), 32'(exp0));
                chk($sformatf("ct_wait1_%0d", k), 32'(m1_waitrequest), 32'(exp1));
            end
            if (k >= 2 && k < 10) begin
                expd = ((k - 2) % 2 == 0) ? 32'hA0000000 + 32'((k - 2) / 2) : 32'hB0000000 + 32'((k - 2) / 2);
                chk($sformatf("ct_vld0_%0d", k), 32'(m0_readdatavalid), 32'((k - 2) % 2 == 0));
                chk($sformatf("ct_vld1_%0d", k), 32'(m1_readdatavalid), 32'((k - 2) % 2 == 1));
                chk($sformatf("ct_data_%0d", k), ((k - 2) % 2 == 0) ? m0_readdata : m1_readdata, expd);
            end else begin
                chk($sformatf("ct_novld_%0d", k), 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
            end
            if (m0_read && !m0_waitrequest) idx0++;
            if (m1_read && !m1_waitrequest) idx1++;
            tick();
        end
        idle();
        tick();

        // Write-to-read hazard at the top address
        m1_write = 1'b1; m1_address = 11'h7FF; m1_writedata = 32'h0000CAFE; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("hz_w_wait", 32'(m1_waitrequest), 32'd0);
        tick();
        idle();
        m0_read = 1'b1; m0_address = 11'h7FF;
        @(negedge clk);
        chk("hz_r_wait", 32'(m0_waitrequest), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("hz_early", 32'(m0_readdatavalid), 32'd0);
        tick();
        @(negedge clk);
        chk("hz_vld", 32'(m0_readdatavalid), 32'd1);
        chk("hz_data", m0_readdata, 32'h0000CAFE);
        tick();

        // Reset mid-flight: read in N, reset in N+1 along with a write that must be dropped
        m0_read = 1'b1; m0_address = 11'h005;
        @(negedge clk);
        chk("rm_accept", 32'(m0_waitrequest), 32'd0);
        tick();
        idle();
        reset = 1'b1;
        m1_write = 1'b1; m1_address = 11'h030; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("rm_wait_in_rst", 32'(m1_waitrequest), 32'd1);
        chk("rm_cs_in_rst", 32'(mem_chipselect), 32'd0);
        tick();
        reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rm_no_vld", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        chk("rm_rdata_clr", m0_readdata, 32'd0);
        tick();
        @(negedge clk);
        chk("rm_no_vld2", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        tick();

        // First contention after reset goes to m0
        m0_read = 1'b1; m0_address = 11'h100;
        m1_read = 1'b1; m1_address = 11'h200;
        @(negedge clk);
        chk("rc_wait0", 32'(m0_waitrequest), 32'd0);
        chk("rc_wait1", 32'(m1_waitrequest), 32'd1);
        tick();
        m0_read = 1'b0;
        @(negedge clk);
        chk("rc_wait1_b", 32'(m1_waitrequest), 32'd0);
        tick();
        idle();
        @(negedge clk);
        chk("rc_vld0", 32'(m0_readdatavalid), 32'd1);
        chk("rc_data0", m0_readdata, 32'hA0000000);
        tick();
        @(negedge clk);
        chk("rc_vld1", 32'(m1_readdatavalid), 32'd1);
        chk("rc_data1", m1_readdata, 32'hB0000000);
        tick();
        tick();
        rd(0, 11'h030, 32'h12345678);

        // Simultaneous read+write from m1 behaves as a write with no response
        m1_read = 1'b1; m1_write = 1'b1; m1_address = 11'h020; m1_writedata = 32'h5; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("rw_wait", 32'(m1_waitrequest), 32'd0);
        chk("rw_mem_write", 32'(mem_write), 32'd1);
        tick();
        idle();
        @(negedge clk);
        chk("rw_no_vld1", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        tick();
        @(negedge clk);
        chk("rw_no_vld2", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        tick();
        rd(1, 11'h020, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter and access sequencer for the 2048x32 single-port on-chip RAM (byte enables, registered address, unregistered q).
- Sits between two Avalon-MM style masters (m0, m1) and the RAM's s1 port. Grants at most one access per cycle and returns read data with fixed latency and per-master valid strobes.

Parameters:
ADDR_W, 11, RAM word-address width (depth 2**ADDR_W)
DATA_W, 32, data width; byte-enable width = DATA_W/8

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_address  in  ADDR_W  master 0 word address
m0_byteenable  in  DATA_W/8  master 0 byte lanes (writes only)
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_waitrequest  out  1  request not accepted this cycle
m0_readdata  out  DATA_W  read data to master 0
m0_readdatavalid  out  1  m0_readdata valid
m1_*  (same seven signals as m0_*, for master 1)
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  DATA_W/8  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; constant 1
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
- Request: mX_req = mX_read | mX_write. If both read and write are asserted, the access is a write and no readdatavalid is generated.
- Arbitration (combinational, per cycle):
  - If only one master requests, it is granted.
  - If both request, the master not in last_grant is granted.
  - last_grant (1 bit) updates to the granted master on every granted cycle and holds otherwise.
- Waitrequest:
  - mX_waitrequest = mX_req & ~grantX.
  - An unrequesting master sees waitrequest=0.
  - A transfer is accepted on a cycle with req & ~waitrequest. Masters hold their signals while waitrequest=1.
- Memory drive (combinational from the granted master):
  - mem_address, mem_writedata, mem_byteenable are muxed from the granted master.
  - mem_chipselect = any grant; mem_write = granted write.
  - With no grant: chipselect=0, write=0, address/data hold the m0 values (don't-care).
  - Read byteenable is forced to all ones.
- Read pipeline:
  - Read accepted in cycle N: RAM q is valid in N+1. The arbiter registers mem_readdata at the end of N+1.
  - mX_readdata and mX_readdatavalid are asserted in cycle N+2 for exactly one cycle. Fixed latency is 2.
  - Tracking is a 2-stage shift register of {valid, master_id}. Stage 1 captures {granted read, id} every cycle, so back-to-back reads are fully pipelined with throughput 1/cycle.
  - readdata is driven to both masters. Only the owner's readdatavalid is set.
- Writes complete in the accept cycle; there is no response. A read accepted in N+1 after a write in N to the same address returns the new data.
- Reset values, applied on the reset clock edge:
  - last_grant=1, so m0 wins the first contention.
  - Pipeline valid bits = 0; both readdatavalid = 0; readdata = 0.
  - Combinational outputs follow inputs, except that during reset all grants are forced to 0: waitrequest=req, chipselect=0.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid is issued for them. Writes in the reset cycle are not performed.
- Fairness: under continuous dual requests, grants strictly alternate m0, m1, m0, ...

Test Plan:
- Reset, then m0 writes 0xDEADBEEF @0x005 be=1111, then m0 reads 0x005 -> write accepted with no wait; m0_readdatavalid high exactly 2 cycles after read accept; data 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: write 0x11223344 @0x010 be=1111, then 0xAABBCCDD be=0101, then read -> 0x11BB33DD.
- Contention: m0 and m1 each issue 4 reads continuously from distinct preloaded addresses -> grants alternate m0,m1,m0,...; each master waits 1 cycle per access; 8 readdatavalid pulses on consecutive cycles, each routed to the correct master with the correct data.
- Write→read hazard: m1 writes 0x0000CAFE @0x7FF (top address) in cycle N; m0 reads 0x7FF in N+1 -> m0 receives 0x0000CAFE at N+3.
- Reset mid-flight: m0 read accepted in N, reset asserted in N+1 -> no readdatavalid at N+2; after release, first contention grants m0.
- Simultaneous read+write from m1 @0x020 with data 0x5 -> treated as a write (readback 0x5); no readdatavalid pulse.
